download_sequencer: RTL and testbench

Parametrised successor to the boot/program downloader. It takes the io-controller byte stream (ioctl-style download, index, addr, data, wr) and buffers it in a small FIFO. It then writes the bytes to SDRAM through a request/acknowledge port, so memory stalls no longer lose bytes. After a PRG load it writes a configurable-width end-of-program pointer, then holds `downloading` for a programmable settle time. Sits between data_io and the SDRAM arbiter.

---
 rtl/download_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_download_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/download_sequencer.sv
// download_sequencer
// Buffers the io-controller download byte stream in a small FIFO and writes
// it to SDRAM over a request/acknowledge port, so memory stalls do not lose
// bytes. After a PRG load it writes a little-endian end-of-program pointer.
// It then holds `downloading` high for a programmable settle time.
//
// Ports:
//   clk           system clock
//   reset_n       synchronous, active-low reset
//   dio_download  download active level from the io controller
//   dio_index     [5:0] menu index (0 = ROM, 1 = PRG, other = ignored), [7:6] unused
//   dio_addr      byte offset within the file
//   dio_data      byte value
//   dio_wr        one-cycle byte strobe
//   mem_wr        SDRAM write request (held until mem_ack)
//   mem_ack       SDRAM accepted the request this cycle
//   mem_addr      SDRAM write address
//   mem_data      SDRAM write data
//   downloading   download or post-processing in progress
//   rom_done      sticky: a non-empty ROM image was loaded since reset
//   overflow      sticky per download: a byte was dropped on a full FIFO
module download_sequencer #(
    parameter int                ADDR_W         = 25,
    parameter int                FIFO_DEPTH     = 4,
    parameter logic [ADDR_W-1:0] ROM_START_ADDR = '0,
    parameter logic [ADDR_W-1:0] PRG_START_ADDR = '0,
    parameter logic [ADDR_W-1:0] PTR_PROGND     = '0,
    parameter logic [31:0]       PTR_END_BASE   = '0,
    parameter int                PTR_BYTES      = 2,
    parameter int                SETTLE_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dio_download,
    input  logic [7:0]        dio_index,
    input  logic [ADDR_W-1:0] dio_addr,
    input  logic [7:0]        dio_data,
    input  logic              dio_wr,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              downloading,
    output logic              rom_done,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_PTR, ST_SETTLE} state_t;
    typedef enum logic [1:0] {DL_ROM, DL_PRG, DL_IGNORE} dl_type_t;

    state_t            state_reg, state_next;
    dl_type_t          dl_type_reg;
    logic              seen_reg;
    logic [ADDR_W-1:0] last_off_reg;
    logic              overflow_reg;
    logic              rom_done_reg;
    logic [1:0]        ptr_k_reg;
    logic [3:0]        settle_reg;

    // FIFO entries carry {address, data}
    logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              fifo_empty, fifo_full;
    logic              push_req, push_ok, pop, drain_done;
    logic              ptr_last, settle_done;
    logic [ADDR_W-1:0] push_base;
    logic [31:0]       ptr_value;
    dl_type_t          idx_type;

    // Extension bits of the menu index carry no meaning here
    logic              unused_index_ext;
    assign unused_index_ext = ^dio_index[7:6];

    assign idx_type    = (dio_index[5:0] == 6'd0) ? DL_ROM :
                         (dio_index[5:0] == 6'd1) ? DL_PRG : DL_IGNORE;
    assign push_base   = (dl_type_reg == DL_ROM) ? ROM_START_ADDR : PRG_START_ADDR;
    assign fifo_empty  = (count_reg == '0);
    assign fifo_full   = (count_reg == CNT_W'(FIFO_DEPTH));
    assign push_req    = (state_reg == ST_XFER) && dio_wr && (dl_type_reg != DL_IGNORE);
    // The FIFO head is the request on the memory port, so an ack pops it
    assign pop         = mem_ack && !fifo_empty;
    assign push_ok     = push_req && (!fifo_full || pop);
    // No pushes happen in DRAIN, so the FIFO empties when its last entry is acked
    assign drain_done  = fifo_empty || ((count_reg == CNT_W'(1)) && pop);
    assign ptr_last    = (ptr_k_reg == 2'(PTR_BYTES - 1));
    assign settle_done = (settle_reg == 4'(SETTLE_CYCLES));
    // Only bytes 0..PTR_BYTES-1 are ever written, which truncates the pointer
    assign ptr_value   = PTR_END_BASE + 32'(last_off_reg) + 32'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (dio_download) state_next = ST_XFER;
            ST_XFER:   if (!dio_download) state_next = ST_DRAIN;
            ST_DRAIN:  if (drain_done)
                           state_next = (dl_type_reg == DL_PRG && seen_reg) ? ST_PTR : ST_SETTLE;
            ST_PTR:    if (mem_ack && ptr_last) state_next = ST_SETTLE;
            ST_SETTLE: if (settle_done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (state_reg == ST_PTR) begin
            mem_wr   = 1'b1;
            mem_addr = PTR_PROGND + ADDR_W'(ptr_k_reg);
            mem_data = ptr_value[{ptr_k_reg, 3'b000} +: 8];
        end else if (!fifo_empty) begin
            mem_wr   = 1'b1;
            mem_addr = fifo_mem[rd_ptr_reg][ADDR_W+7:8];
            mem_data = fifo_mem[rd_ptr_reg][7:0];
        end
    end

    assign downloading = (state_reg != ST_IDLE);
    assign rom_done    = rom_done_reg;
    assign overflow    = overflow_reg;

    // FIFO storage; pointers are reset, contents need not be
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= {push_base + dio_addr, dio_data};
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            dl_type_reg  <= DL_IGNORE;
            seen_reg     <= 1'b0;
            last_off_reg <= '0;
            overflow_reg <= 1'b0;
            rom_done_reg <= 1'b0;
            ptr_k_reg    <= '0;
            settle_reg   <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (state_reg == ST_IDLE && dio_download) begin
                dl_type_reg  <= idx_type;
                seen_reg     <= 1'b0;
                last_off_reg <= '0;
                overflow_reg <= 1'b0;
            end

            // The offset is tracked even for a dropped byte: it still marks file length
            if (push_req) begin
                seen_reg     <= 1'b1;
                last_off_reg <= dio_addr;
                if (!push_ok) overflow_reg <= 1'b1;
            end

            if (state_reg == ST_DRAIN) begin
                ptr_k_reg <= '0;
            end else if (state_reg == ST_PTR && mem_ack) begin
                ptr_k_reg <= ptr_k_reg + 1'b1;
            end

            settle_reg <= (state_reg == ST_SETTLE) ? settle_reg + 1'b1 : 4'd0;

            if (state_reg == ST_SETTLE && settle_done && dl_type_reg == DL_ROM && seen_reg) begin
                rom_done_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_download_sequencer.sv
// Testbench for download_sequencer. Two instances share all inputs:
// dut_a uses a 2-byte pointer, and dut_b a 3-byte pointer that wraps.
module tb_download_sequencer;

    localparam int ADDR_W = 25;
    localparam int SETTLE = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              dio_download = 1'b0;
    logic [7:0]        dio_index = '0;
    logic [ADDR_W-1:0] dio_addr = '0;
    logic [7:0]        dio_data = '0;
    logic              dio_wr = 1'b0;
    logic              mem_ack = 1'b1;

    logic              a_mem_wr, a_downloading, a_rom_done, a_overflow;
    logic [ADDR_W-1:0] a_mem_addr;
    logic [7:0]        a_mem_data;
    logic              b_mem_wr, b_downloading, b_rom_done, b_overflow;
    logic [ADDR_W-1:0] b_mem_addr;
    logic [7:0]        b_mem_data;

    download_sequencer #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(4),
        .ROM_START_ADDR(25'h0), .PRG_START_ADDR(25'h10000),
        .PTR_PROGND(25'h83E9), .PTR_END_BASE(32'h8995),
        .PTR_BYTES(2), .SETTLE_CYCLES(SETTLE)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .dio_download(dio_download), .dio_index(dio_index),
        .dio_addr(dio_addr), .dio_data(dio_data), .dio_wr(dio_wr),
        .mem_wr(a_mem_wr), .mem_ack(mem_ack), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
        .downloading(a_downloading), .rom_done(a_rom_done), .overflow(a_overflow)
    );

    download_sequencer #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(4),
        .ROM_START_ADDR(25'h0), .PRG_START_ADDR(25'h10000),
        .PTR_PROGND(25'h100), .PTR_END_BASE(32'hFFFFFF),
        .PTR_BYTES(3), .SETTLE_CYCLES(SETTLE)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .dio_download(dio_download), .dio_index(dio_index),
        .dio_addr(dio_addr), .dio_data(dio_data), .dio_wr(dio_wr),
        .mem_wr(b_mem_wr), .mem_ack(mem_ack), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
        .downloading(b_downloading), .rom_done(b_rom_done), .overflow(b_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    typedef struct {
        logic [7:0] idx;
        int         n;
        logic [7:0] d0;
        int         ack_hold;
        int         exp_first;
        int         exp_cnt;
        logic       exp_rom;
        logic       exp_ovf;
    } vec_t;

    wr_t  a_log[$];
    wr_t  b_log[$];
    int   a_last_wr_cyc = -1;
    int   ack_low_left = 0;
    int   tests = 0;
    int   fails = 0;

    // Accepted writes, sampled mid-cycle while inputs and outputs are stable
    always @(negedge clk) begin
        #2;
        if (a_mem_wr && mem_ack) begin
            a_log.push_back('{a_mem_addr, a_mem_data});
            a_last_wr_cyc = cyc;
        end
        if (b_mem_wr && mem_ack) b_log.push_back('{b_mem_addr, b_mem_data});
    end

    // Acknowledge generator: low for ack_low_left cycles, otherwise high
    always @(negedge clk) begin
        if (ack_low_left > 0) begin
            mem_ack = 1'b0;
            ack_low_left = ack_low_left - 1;
        end else begin
            mem_ack = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_dl(input logic [7:0] idx, input int n, input logic [7:0] d0,
                            input int ack_hold);
        @(negedge clk);
        dio_download = 1'b1;
        dio_index    = idx;
        ack_low_left = ack_hold;
        @(negedge clk);
        chk("downloading_rise", {31'd0, a_downloading}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            dio_wr   = 1'b1;
            dio_addr = ADDR_W'(i);
            dio_data = d0 + 8'(i);
            if (i == n - 1) dio_download = 1'b0;
        end
        if (n == 0) dio_download = 1'b0;
        @(negedge clk);
        dio_wr       = 1'b0;
        dio_download = 1'b0;
    endtask

    task automatic wait_idle(output int fall_cyc);
        for (int t = 0; t < 300; t++) begin
            if (!a_downloading) break;
            @(negedge clk);
        end
        fall_cyc = cyc;
        chk("idle_timeout", {31'd0, a_downloading}, 32'd0);
    endtask

    task automatic expect_a(input string name, input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        wr_t w;
        if (a_log.size() == 0) begin
            chk({name, "_missing"}, 32'd0, 32'd1);
        end else begin
            w = a_log.pop_front();
            chk({name, "_addr"}, 32'(w.addr), 32'(addr));
            chk({name, "_data"}, 32'(w.data), 32'(data));
        end
    endtask

    task automatic expect_b(input string name, input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        wr_t w;
        if (b_log.size() == 0) begin
            chk({name, "_missing"}, 32'd0, 32'd1);
        end else begin
            w = b_log.pop_front();
            chk({name, "_addr"}, 32'(w.addr), 32'(addr));
            chk({name, "_data"}, 32'(w.data), 32'(data));
        end
    endtask

    vec_t vecs[5];
    wr_t  exp_wr[14];

    initial begin
        int fall;

        // PRG 3 bytes: pointer = 0x8995 + 2 + 1 = 0x8998
        vecs[0] = '{8'h01, 3, 8'h10, 0,  0, 5, 1'b0, 1'b0};
        // ROM 3 bytes, extension bits set in the index
        vecs[1] = '{8'hC0, 3, 8'hA0, 0,  5, 3, 1'b1, 1'b0};
        // PRG 6 bytes into a stalled FIFO: 2 dropped, last offset 5 -> 0x899B
        vecs[2] = '{8'h01, 6, 8'h20, 10, 8, 6, 1'b1, 1'b1};
        // Menu 2: ignored, overflow cleared at start, rom_done unchanged
        vecs[3] = '{8'h42, 4, 8'h30, 0,  0, 0, 1'b1, 1'b0};
        // Zero-byte PRG: no pointer write
        vecs[4] = '{8'h01, 0, 8'h00, 0,  0, 0, 1'b1, 1'b0};

        exp_wr[0]  = '{25'h10000, 8'h10};
        exp_wr[1]  = '{25'h10001, 8'h11};
        exp_wr[2]  = '{25'h10002, 8'h12};
        exp_wr[3]  = '{25'h083E9, 8'h98};
        exp_wr[4]  = '{25'h083EA, 8'h89};
        exp_wr[5]  = '{25'h00000, 8'hA0};
        exp_wr[6]  = '{25'h00001, 8'hA1};
        exp_wr[7]  = '{25'h00002, 8'hA2};
        exp_wr[8]  = '{25'h10000, 8'h20};
        exp_wr[9]  = '{25'h10001, 8'h21};
        exp_wr[10] = '{25'h10002, 8'h22};
        exp_wr[11] = '{25'h10003, 8'h23};
        exp_wr[12] = '{25'h083E9, 8'h9B};
        exp_wr[13] = '{25'h083EA, 8'h89};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_wr", {31'd0, a_mem_wr}, 32'd0);
        chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
        chk("rst_mem_data", 32'(a_mem_data), 32'd0);
        chk("rst_downloading", {31'd0, a_downloading}, 32'd0);
        chk("rst_rom_done", {31'd0, a_rom_done}, 32'd0);
        chk("rst_overflow", {31'd0, a_overflow}, 32'd0);
        chk("rst_b_mem_wr", {31'd0, b_mem_wr}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            a_log.delete();
            b_log.delete();
            a_last_wr_cyc = -1;
            start_dl(vecs[v].idx, vecs[v].n, vecs[v].d0, vecs[v].ack_hold);
            wait_idle(fall);
            repeat (3) @(negedge clk);
            $display("[TB] vec %0d idx=0x%02h bytes=%0d writes=%0d rom_done=%0b overflow=%0b",
                     v, vecs[v].idx, vecs[v].n, a_log.size(), a_rom_done, a_overflow);
            for (int j = 0; j < vecs[v].exp_cnt; j++)
                expect_a($sformatf("v%0d_wr%0d", v, j),
                         exp_wr[vecs[v].exp_first + j].addr, exp_wr[vecs[v].exp_first + j].data);
            chk($sformatf("v%0d_extra_writes", v), 32'(a_log.size()), 32'd0);
            chk($sformatf("v%0d_rom_done", v), {31'd0, a_rom_done}, {31'd0, vecs[v].exp_rom});
            chk($sformatf("v%0d_overflow", v), {31'd0, a_overflow}, {31'd0, vecs[v].exp_ovf});
            // Last accepted write ends at edge A; downloading drops at edge A+SETTLE+1,
            // seen from the sample of the last write as SETTLE+2 samples later.
            if (vecs[v].exp_cnt > 0)
                chk($sformatf("v%0d_settle", v), 32'(fall - a_last_wr_cyc), 32'(SETTLE + 2));
        end

        // Reset while the pointer is being written
        a_log.delete();
        start_dl(8'h01, 2, 8'h60, 0);
        for (int t = 0; t < 50; t++) begin
            if (a_mem_wr && a_mem_addr == 25'h083E9) break;
            @(negedge clk);
        end
        chk("ptr_reached", {31'd0, a_mem_wr}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_mem_wr", {31'd0, a_mem_wr}, 32'd0);
        chk("midrst_mem_addr", 32'(a_mem_addr), 32'd0);
        chk("midrst_downloading", {31'd0, a_downloading}, 32'd0);
        chk("midrst_rom_done", {31'd0, a_rom_done}, 32'd0);
        chk("midrst_b_mem_wr", {31'd0, b_mem_wr}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_fifo_empty", {31'd0, a_mem_wr}, 32'd0);
        $display("[TB] reset during pointer write, rom_done=%0b", a_rom_done);

        // Zero-byte ROM leaves rom_done clear
        a_log.delete();
        start_dl(8'h00, 0, 8'h00, 0);
        wait_idle(fall);
        repeat (2) @(negedge clk);
        chk("rom0_rom_done", {31'd0, a_rom_done}, 32'd0);
        chk("rom0_writes", 32'(a_log.size()), 32'd0);
        $display("[TB] zero-byte ROM writes=%0d rom_done=%0b", a_log.size(), a_rom_done);

        // Fresh ROM download after reset
        a_log.delete();
        start_dl(8'h00, 2, 8'h70, 0);
        wait_idle(fall);
        repeat (2) @(negedge clk);
        expect_a("post_rst_wr0", 25'h0, 8'h70);
        expect_a("post_rst_wr1", 25'h1, 8'h71);
        chk("post_rst_extra", 32'(a_log.size()), 32'd0);
        chk("post_rst_rom_done", {31'd0, a_rom_done}, 32'd1);
        $display("[TB] ROM after reset rom_done=%0b", a_rom_done);

        // 3-byte pointer wrap: 0xFFFFFF + 0 + 1 truncates to 0x000000
        a_log.delete();
        b_log.delete();
        start_dl(8'h01, 1, 8'h55, 0);
        wait_idle(fall);
        for (int t = 0; t < 50; t++) begin
            if (!b_downloading) break;
            @(negedge clk);
        end
        chk("b_idle_timeout", {31'd0, b_downloading}, 32'd0);
        repeat (2) @(negedge clk);
        expect_a("wrap_a_wr0", 25'h10000, 8'h55);
        expect_a("wrap_a_ptr0", 25'h083E9, 8'h96);
        expect_a("wrap_a_ptr1", 25'h083EA, 8'h89);
        expect_b("wrap_b_wr0", 25'h10000, 8'h55);
        expect_b("wrap_b_ptr0", 25'h00100, 8'h00);
        expect_b("wrap_b_ptr1", 25'h00101, 8'h00);
        expect_b("wrap_b_ptr2", 25'h00102, 8'h00);
        chk("wrap_b_extra", 32'(b_log.size()), 32'd0);
        $display("[TB] pointer wrap test done, b remaining=%0d", b_log.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
